// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache/memory arbiter slice.
// Contents:
// - dcache_wlen encodings: byte, half, word, dword.
// - Bit positions within the ctrl buses: STALL and FLUSH.
// - Arbiter FSM state encoding.
// - Owner of the in-flight transaction: fetch side or data side.
// - A helper that returns the unshifted byte-lane mask for an access size.
package cache_mem_arbiter_pkg;

  localparam logic [1:0] WLEN_BYTE  = 2'b00;
  localparam logic [1:0] WLEN_HALF  = 2'b01;
  localparam logic [1:0] WLEN_WORD  = 2'b10;
  localparam logic [1:0] WLEN_DWORD = 2'b11;

  localparam int CTRL_STALL_BIT = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Unshifted lane mask for an access size, anchored at byte lane 0.
  function automatic logic [7:0] wlen_base_mask(input logic [1:0] wlen);
    logic [7:0] mask;
    case (wlen)
      WLEN_BYTE: mask = 8'h01;
      WLEN_HALF: mask = 8'h03;
      WLEN_WORD: mask = 8'h0F;
      default:   mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_lane_align.sv
// mem_lane_align: combinational byte-lane steering for data-side accesses.
// Ports:
// - off_i      in   3       byte offset within the dword (addr[2:0])
// - wlen_i     in   2       access size (byte/half/word/dword)
// - wen_i      in   1       1 = store, 0 = load
// - wdata_i    in   DATA_W  right-justified store data
// - wstrb_o    out  8       byte strobes; all lanes on a load
// - wdata_o    out  DATA_W  store data moved up to its byte lane
// - misalign_o out  1       access spills past byte lane 7
module mem_lane_align
  import cache_mem_arbiter_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]        off_i,
  input  logic [1:0]        wlen_i,
  input  logic              wen_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [7:0]        wstrb_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              misalign_o
);

  logic [15:0] mask_wide;

  // The mask is shifted in a 16-bit field so that lanes pushed past lane 7
  // land in the upper byte.  Those lanes are dropped from the strobes, and
  // any of them being set means the access crossed the dword boundary.
  always_comb begin
    mask_wide  = {8'h00, wlen_base_mask(wlen_i)} << off_i;
    wstrb_o    = wen_i ? mask_wide[7:0] : 8'hFF;
    misalign_o = |mask_wide[15:8];
    wdata_o    = wdata_i << {off_i, 3'b000};
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares a single memory port between instruction fetch
// and data access, with one transaction outstanding at a time.
// Ports:
// - clk, rst                      clock and synchronous active-high reset
// - icache_req_valid_i/addr/ctrl  fetch request, FLUSH/STALL control
// - icache_ready_o                a fetch can be accepted this cycle
// - icache_data_valid_o/data_o    one-cycle instruction return
// - dcache_req_valid_i/wen/addr/wdata/wlen/ctrl  load/store request
// - dcache_ready_o                a data request can be accepted this cycle
// - dcache_data_valid_o/data_o    one-cycle load data / store completion
// - misalign_o                    data access crossed an 8-byte boundary
// - mem_req_o/we/addr/wdata/wstrb memory request, held until mem_gnt_i
// - mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory handshake and read data
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req_valid_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  input  logic [CTRL_W-1:0] icache_ctrl_i,
  output logic              icache_ready_o,
  output logic              icache_data_valid_o,
  output logic [INST_W-1:0] icache_data_o,
  input  logic              dcache_req_valid_i,
  input  logic              dcache_wen_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic [DATA_W-1:0] dcache_wdata_i,
  input  logic [1:0]        dcache_wlen_i,
  input  logic [CTRL_W-1:0] dcache_ctrl_i,
  output logic              dcache_ready_o,
  output logic              dcache_data_valid_o,
  output logic [DATA_W-1:0] dcache_data_o,
  output logic              misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [7:0]        mem_wstrb_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic              flush_q, flush_d;
  logic [DATA_W-1:0] resp_q, resp_d;

  logic              accept_d;
  logic              accept_i;
  logic              owner_flush;
  logic [7:0]        lane_wstrb;
  logic [DATA_W-1:0] lane_wdata;
  logic              lane_misalign;

  // STALL never changes arbiter behaviour: a transaction in flight runs to
  // completion and the response pulse is issued once regardless.
  logic unused_stall;
  assign unused_stall = icache_ctrl_i[CTRL_STALL_BIT] ^ dcache_ctrl_i[CTRL_STALL_BIT];

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .off_i      (dcache_addr_i[2:0]),
    .wlen_i     (dcache_wlen_i),
    .wen_i      (dcache_wen_i),
    .wdata_i    (dcache_wdata_i),
    .wstrb_o    (lane_wstrb),
    .wdata_o    (lane_wdata),
    .misalign_o (lane_misalign)
  );

  // Acceptance only happens in IDLE outside reset.  The data side wins a
  // tie because its instruction is older in the pipe; a FLUSH on a side
  // vetoes that side's same-cycle request.
  always_comb begin
    accept_d = 1'b0;
    accept_i = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      accept_d = dcache_req_valid_i && !dcache_ctrl_i[CTRL_FLUSH_BIT];
      accept_i = icache_req_valid_i && !icache_ctrl_i[CTRL_FLUSH_BIT] && !accept_d;
    end
    owner_flush = (owner_q == OWN_I) ? icache_ctrl_i[CTRL_FLUSH_BIT]
                                     : dcache_ctrl_i[CTRL_FLUSH_BIT];
  end

  // Next-state logic: request capture on accept, grant wait, response wait,
  // and a single response cycle.  A FLUSH seen while the transaction is on
  // the memory side is remembered so the response pulse can be dropped.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    flush_d = flush_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_d) begin
          state_d = ST_REQ;
          owner_d = OWN_D;
          we_d    = dcache_wen_i;
          addr_d  = {dcache_addr_i[ADDR_W-1:3], 3'b000};
          off_d   = dcache_addr_i[2:0];
          wdata_d = lane_wdata;
          wstrb_d = lane_wstrb;
          flush_d = 1'b0;
        end else if (accept_i) begin
          state_d = ST_REQ;
          owner_d = OWN_I;
          we_d    = 1'b0;
          addr_d  = {icache_addr_i[ADDR_W-1:3], 3'b000};
          off_d   = icache_addr_i[2:0];
          wdata_d = '0;
          wstrb_d = 8'hFF;
          flush_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (owner_flush) flush_d = 1'b1;
        if (mem_gnt_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (owner_flush) flush_d = 1'b1;
        if (mem_rvalid_i) begin
          state_d = ST_RESP;
          if (owner_q == OWN_I) begin
            resp_d = {{(DATA_W-INST_W){1'b0}},
                      off_q[2] ? mem_rdata_i[2*INST_W-1:INST_W] : mem_rdata_i[INST_W-1:0]};
          end else begin
            resp_d = mem_rdata_i >> {off_q, 3'b000};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      off_q   <= 3'b000;
      wdata_q <= '0;
      wstrb_q <= 8'h00;
      flush_q <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      flush_q <= flush_d;
      resp_q  <= resp_d;
    end
  end

  assign icache_ready_o      = (state_q == ST_IDLE) && !rst;
  assign dcache_ready_o      = (state_q == ST_IDLE) && !rst;
  assign icache_data_valid_o = (state_q == ST_RESP) && (owner_q == OWN_I) && !flush_q;
  assign dcache_data_valid_o = (state_q == ST_RESP) && (owner_q == OWN_D) && !flush_q;
  assign icache_data_o       = resp_q[INST_W-1:0];
  assign dcache_data_o       = resp_q;
  assign misalign_o          = accept_d && lane_misalign;
  assign mem_req_o           = (state_q == ST_REQ);
  assign mem_we_o            = we_q;
  assign mem_addr_o          = addr_q;
  assign mem_wdata_o         = wdata_q;
  assign mem_wstrb_o         = wstrb_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: table of data-side vectors plus
// hand-written fetch, priority, flush and reset sequences.  A small memory
// responder answers requests; returned data is checked through per-side
// scoreboards filled when each request is driven.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_req_valid_i = 1'b0;
  logic [63:0] icache_addr_i = '0;
  logic [1:0]  icache_ctrl_i = '0;
  logic        icache_ready_o, icache_data_valid_o;
  logic [31:0] icache_data_o;
  logic        dcache_req_valid_i = 1'b0;
  logic        dcache_wen_i = 1'b0;
  logic [63:0] dcache_addr_i = '0;
  logic [63:0] dcache_wdata_i = '0;
  logic [1:0]  dcache_wlen_i = '0;
  logic [1:0]  dcache_ctrl_i = '0;
  logic        dcache_ready_o, dcache_data_valid_o;
  logic [63:0] dcache_data_o;
  logic        misalign_o;
  logic        mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [63:0] mem_rdata_i = '0;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_req_valid_i(icache_req_valid_i), .icache_addr_i(icache_addr_i),
    .icache_ctrl_i(icache_ctrl_i), .icache_ready_o(icache_ready_o),
    .icache_data_valid_o(icache_data_valid_o), .icache_data_o(icache_data_o),
    .dcache_req_valid_i(dcache_req_valid_i), .dcache_wen_i(dcache_wen_i),
    .dcache_addr_i(dcache_addr_i), .dcache_wdata_i(dcache_wdata_i),
    .dcache_wlen_i(dcache_wlen_i), .dcache_ctrl_i(dcache_ctrl_i),
    .dcache_ready_o(dcache_ready_o), .dcache_data_valid_o(dcache_data_valid_o),
    .dcache_data_o(dcache_data_o), .misalign_o(misalign_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [1:0]  wlen;
    logic [63:0] wdata;
    logic [63:0] exp_maddr;
    logic [7:0]  exp_wstrb;
    logic [63:0] exp_mwdata;
    logic        exp_mis;
  } dvec_t;

  typedef struct {
    logic [63:0] data;
    bit          chk_data;
    int          acc_cyc;
    int          exp_lat;
  } sb_t;

  sb_t iq[$];
  sb_t dq[$];
  sb_t ie, de;
  int  checks = 0;
  int  passes = 0;
  int  cyc = 0;
  int  ipulses = 0, dpulses = 0;
  int  last_i_cyc = 0, last_d_cyc = 0;
  int  gnt_dly = 0, rsp_dly = 0;
  int  rvalid_cnt = 0;
  dvec_t vecs[9];

  // Free-running cycle count used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Bench memory contents: one fixed dword for the fetch case, a simple
  // address hash everywhere else.
  function automatic logic [63:0] memVal(input logic [63:0] a);
    if (a == 64'h1000) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {a[31:0] ^ 32'h5A5A_0F0F, a[31:0] + 32'h0101_0101};
  endfunction

  // Load result seen by the core: byte b comes from memory lane off+b,
  // lanes beyond 7 read as zero.
  function automatic logic [63:0] loadModel(input logic [63:0] d, input logic [2:0] off);
    logic [63:0] r = '0;
    for (int b = 0; b < 8; b++)
      if (int'(off) + b < 8) r[8*b +: 8] = d[8*(int'(off)+b) +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: grants gnt_dly cycles after a request is seen and
  // returns read data / write ack rsp_dly cycles after the grant.
  initial begin
    int gcnt = 0, rcnt = 0;
    bit granted = 0;
    logic [63:0] gaddr = '0;
    forever begin
      tick();
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (granted) begin
        if (rcnt >= rsp_dly) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = memVal(gaddr);
          rvalid_cnt++;
          granted = 0;
          rcnt = 0;
        end else rcnt++;
      end else if (mem_req_o) begin
        if (gcnt >= gnt_dly) begin
          mem_gnt_i = 1'b1;
          gaddr = mem_addr_o;
          granted = 1;
          gcnt = 0;
        end else gcnt++;
      end
    end
  end

  // Response monitor: every pulse must match the oldest scoreboard entry
  // for its side.
  always @(negedge clk) begin
    if (!rst && icache_data_valid_o) begin
      ipulses++;
      last_i_cyc = cyc;
      checkOutput("i_pulse_expected", 64'(iq.size() > 0), 64'd1);
      if (iq.size() > 0) begin
        ie = iq.pop_front();
        if (ie.chk_data) checkOutput("i_data", 64'(icache_data_o), ie.data);
        if (ie.exp_lat >= 0) checkOutput("i_latency", 64'(cyc - ie.acc_cyc), 64'(ie.exp_lat));
      end
    end
    if (!rst && dcache_data_valid_o) begin
      dpulses++;
      last_d_cyc = cyc;
      checkOutput("d_pulse_expected", 64'(dq.size() > 0), 64'd1);
      if (dq.size() > 0) begin
        de = dq.pop_front();
        if (de.chk_data) checkOutput("d_data", dcache_data_o, de.data);
        if (de.exp_lat >= 0) checkOutput("d_latency", 64'(cyc - de.acc_cyc), 64'(de.exp_lat));
      end
    end
  end

  // Drives one data-side request, checks the misalign pulse in the accept
  // cycle and the memory-side fields in the first REQ cycle.
  task automatic applyStimulus(input dvec_t v, input string name, input bit push, input int exp_lat);
    int n = 0;
    sb_t e;
    while (!dcache_ready_o && n < 50) begin tick(); n++; end
    checkOutput({name, "_dready"}, 64'(dcache_ready_o), 64'd1);
    dcache_req_valid_i = 1'b1;
    dcache_wen_i = v.wen;
    dcache_addr_i = v.addr;
    dcache_wlen_i = v.wlen;
    dcache_wdata_i = v.wdata;
    e.data = loadModel(memVal(v.exp_maddr), v.addr[2:0]);
    e.chk_data = !v.wen;
    e.acc_cyc = cyc;
    e.exp_lat = exp_lat;
    #1;
    checkOutput({name, "_misalign"}, 64'(misalign_o), 64'(v.exp_mis));
    if (push) dq.push_back(e);
    tick();
    dcache_req_valid_i = 1'b0;
    checkOutput({name, "_mreq"}, 64'(mem_req_o), 64'd1);
    checkOutput({name, "_maddr"}, mem_addr_o, v.exp_maddr);
    checkOutput({name, "_mwe"}, 64'(mem_we_o), 64'(v.wen));
    checkOutput({name, "_mwstrb"}, 64'(mem_wstrb_o), 64'(v.exp_wstrb));
    if (v.wen) checkOutput({name, "_mwdata"}, mem_wdata_o, v.exp_mwdata);
  endtask

  // Drives one fetch request; returns in the first REQ cycle.
  task automatic applyFetch(input logic [63:0] addr, input string name, input bit push, input int exp_lat);
    int n = 0;
    sb_t e;
    logic [63:0] d;
    while (!icache_ready_o && n < 50) begin tick(); n++; end
    checkOutput({name, "_iready"}, 64'(icache_ready_o), 64'd1);
    icache_req_valid_i = 1'b1;
    icache_addr_i = addr;
    d = memVal({addr[63:3], 3'b000});
    e.data = addr[2] ? {32'h0, d[63:32]} : {32'h0, d[31:0]};
    e.chk_data = 1;
    e.acc_cyc = cyc;
    e.exp_lat = exp_lat;
    if (push) iq.push_back(e);
    tick();
    icache_req_valid_i = 1'b0;
    checkOutput({name, "_maddr"}, mem_addr_o, {addr[63:3], 3'b000});
    checkOutput({name, "_mwstrb"}, 64'(mem_wstrb_o), 64'hFF);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0) && n < 60) begin tick(); n++; end
    checkOutput({name, "_drained"}, 64'(iq.size() + dq.size()), 64'd0);
    tick();
  endtask

  initial begin
    int p0, r0, n;
    sb_t e;
    // wen, addr, wlen, wdata, exp mem addr, exp strobes, exp mem wdata, exp misalign
    vecs[0] = '{1'b1, 64'h3000, 2'b00, 64'hAB,                  64'h3000, 8'h01, 64'hAB,                  1'b0};
    vecs[1] = '{1'b1, 64'h3007, 2'b00, 64'h5A,                  64'h3000, 8'h80, 64'h5A00_0000_0000_0000, 1'b0};
    vecs[2] = '{1'b1, 64'h2006, 2'b01, 64'h1234,                64'h2000, 8'hC0, 64'h1234_0000_0000_0000, 1'b0};
    vecs[3] = '{1'b1, 64'h2006, 2'b10, 64'h1234,                64'h2000, 8'hC0, 64'h1234_0000_0000_0000, 1'b1};
    vecs[4] = '{1'b1, 64'h4000, 2'b11, 64'h0123_4567_89AB_CDEF, 64'h4000, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[5] = '{1'b1, 64'h4004, 2'b10, 64'hDEAD_BEEF,           64'h4000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 1'b0};
    vecs[6] = '{1'b1, 64'h4001, 2'b11, 64'h1122_3344_5566_7788, 64'h4000, 8'hFE, 64'h2233_4455_6677_8800, 1'b1};
    vecs[7] = '{1'b0, 64'h5004, 2'b10, 64'h0,                   64'h5000, 8'hFF, 64'h0,                   1'b0};
    vecs[8] = '{1'b0, 64'h5003, 2'b11, 64'h0,                   64'h5000, 8'hFF, 64'h0,                   1'b1};

    // Reset behaviour: not ready while held, ready and quiet afterwards.
    repeat (3) tick();
    checkOutput("rst_iready", 64'(icache_ready_o), 64'd0);
    checkOutput("rst_dready", 64'(dcache_ready_o), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_iready", 64'(icache_ready_o), 64'd1);
    checkOutput("post_rst_dready", 64'(dcache_ready_o), 64'd1);
    checkOutput("post_rst_mreq", 64'(mem_req_o), 64'd0);
    checkOutput("post_rst_wstrb", 64'(mem_wstrb_o), 64'd0);

    // Fetch from 0x1004 at minimum latency.
    applyFetch(64'h1004, "fetch_hi", 1, 3);
    drain("fetch_hi");

    // Data-side vector table, minimum-latency memory.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i), 1, 3);
      drain($sformatf("vec%0d", i));
    end

    // Slow memory with STALL held: latency grows, pulse still issued once.
    gnt_dly = 2; rsp_dly = 3;
    icache_ctrl_i = 2'b01;
    p0 = ipulses;
    applyFetch(64'h1000, "fetch_slow", 1, 8);
    drain("fetch_slow");
    repeat (4) tick();
    icache_ctrl_i = 2'b00;
    checkOutput("stall_single_pulse", 64'(ipulses - p0), 64'd1);
    gnt_dly = 0; rsp_dly = 0;

    // Simultaneous requests: the data side goes first, fetch follows.
    icache_req_valid_i = 1'b1; icache_addr_i = 64'h1000;
    dcache_req_valid_i = 1'b1; dcache_wen_i = 1'b0;
    dcache_addr_i = 64'h5004; dcache_wlen_i = 2'b10;
    e.data = loadModel(memVal(64'h5000), 3'd4); e.chk_data = 1; e.acc_cyc = cyc; e.exp_lat = 3;
    dq.push_back(e);
    e.data = 64'hCCCC_DDDD; e.chk_data = 1; e.acc_cyc = cyc; e.exp_lat = -1;
    iq.push_back(e);
    tick();
    dcache_req_valid_i = 1'b0;
    checkOutput("both_first_addr", mem_addr_o, 64'h5000);
    n = 0;
    while (!icache_ready_o && n < 50) begin tick(); n++; end
    tick();
    icache_req_valid_i = 1'b0;
    checkOutput("both_second_addr", mem_addr_o, 64'h1000);
    drain("both");
    checkOutput("both_order", 64'(last_d_cyc < last_i_cyc), 64'd1);

    // FLUSH in IDLE with a same-cycle fetch: request refused.
    icache_req_valid_i = 1'b1; icache_addr_i = 64'h1000; icache_ctrl_i = 2'b10;
    tick();
    icache_req_valid_i = 1'b0; icache_ctrl_i = 2'b00;
    checkOutput("flush_idle_mreq", 64'(mem_req_o), 64'd0);
    checkOutput("flush_idle_ready", 64'(icache_ready_o), 64'd1);

    // FLUSH during WAIT: memory completes, no pulse, next fetch is normal.
    rsp_dly = 3;
    p0 = ipulses; r0 = rvalid_cnt;
    applyFetch(64'h1008, "flush_wait", 0, -1);
    tick();
    icache_ctrl_i = 2'b10;
    tick();
    icache_ctrl_i = 2'b00;
    repeat (8) tick();
    checkOutput("flush_wait_nopulse", 64'(ipulses - p0), 64'd0);
    checkOutput("flush_wait_mem_done", 64'(rvalid_cnt - r0), 64'd1);
    rsp_dly = 0;
    applyFetch(64'h1004, "after_flush", 1, 3);
    drain("after_flush");

    // Reset during WAIT with a late read response.
    rsp_dly = 4;
    p0 = ipulses; r0 = rvalid_cnt;
    applyFetch(64'h1010, "rst_wait", 0, -1);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_wait_ready_low", 64'(icache_ready_o), 64'd0);
    rst = 1'b0;
    #1;
    repeat (8) tick();
    checkOutput("rst_wait_nopulse", 64'(ipulses - p0), 64'd0);
    checkOutput("rst_wait_late_rvalid", 64'(rvalid_cnt - r0), 64'd1);
    checkOutput("rst_wait_ready", 64'(icache_ready_o), 64'd1);
    checkOutput("rst_wait_idata", 64'(icache_data_o), 64'd0);
    checkOutput("rst_wait_ddata", dcache_data_o, 64'd0);
    checkOutput("rst_wait_mreq", 64'(mem_req_o), 64'd0);
    checkOutput("rst_wait_wstrb", 64'(mem_wstrb_o), 64'd0);
    rsp_dly = 0;
    applyStimulus(vecs[7], "after_rst", 1, 3);
    drain("after_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout passed=%0d checks=%0d", passes, checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
